// File: rtl/mod5_seq_monitor.sv
// rtl/mod5_seq_monitor.sv - sequence monitor for an upstream mod-5 counter
module mod5_seq_monitor #(
    parameter int unsigned LOCK_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cnt_in,
    input  logic       en,
    input  logic       clr,
    output logic       locked,
    output logic       err,
    output logic       illegal,
    output logic       wrap,
    output logic [7:0] err_cnt,
    output logic [7:0] wrap_cnt
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [2:0] prev, prev_nxt, expected;
    logic [3:0] good, good_nxt, good_inc;
    logic       err_nxt, illegal_nxt, wrap_nxt;
    logic [7:0] err_cnt_nxt, wrap_cnt_nxt, err_cnt_inc;
    logic       legal, match;

    assign expected    = (prev == 3'd4) ? 3'd0 : prev + 3'd1;
    assign legal       = (cnt_in <= 3'd4);
    assign match       = (cnt_in == expected);
    assign good_inc    = good + 4'd1;
    assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign locked      = (state == LOCKED);

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev;
        good_nxt     = good;
        err_nxt      = 1'b0;
        illegal_nxt  = 1'b0;
        wrap_nxt     = 1'b0;
        err_cnt_nxt  = err_cnt;
        wrap_cnt_nxt = wrap_cnt;
        if (en) begin
            case (state)
                HUNT: begin
                    if (legal) begin
                        prev_nxt  = cnt_in;
                        good_nxt  = 4'd0;
                        state_nxt = CHECK;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
                CHECK: begin
                    if (!legal) begin
                        illegal_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end else if (match) begin
                        prev_nxt = cnt_in;
                        good_nxt = good_inc;
                        if (good_inc == 4'(LOCK_N))
                            state_nxt = LOCKED;
                    end else begin
                        prev_nxt = cnt_in;
                        good_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        err_nxt     = 1'b1;
                        illegal_nxt = 1'b1;
                        err_cnt_nxt = err_cnt_inc;
                        good_nxt    = 4'd0;
                        state_nxt   = HUNT;
                    end else if (match) begin
                        prev_nxt = cnt_in;
                        // a match from 4 can only be 0, so this is the wrap point
                        if (prev == 3'd4) begin
                            wrap_nxt     = 1'b1;
                            wrap_cnt_nxt = wrap_cnt + 8'd1;
                        end
                    end else begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = err_cnt_inc;
                        prev_nxt    = cnt_in;
                        good_nxt    = 4'd0;
                        state_nxt   = CHECK;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (clr) begin
            err_cnt_nxt  = 8'd0;
            wrap_cnt_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            prev     <= 3'd0;
            good     <= 4'd0;
            err      <= 1'b0;
            illegal  <= 1'b0;
            wrap     <= 1'b0;
            err_cnt  <= 8'd0;
            wrap_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            good     <= good_nxt;
            err      <= err_nxt;
            illegal  <= illegal_nxt;
            wrap     <= wrap_nxt;
            err_cnt  <= err_cnt_nxt;
            wrap_cnt <= wrap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mod5_seq_monitor.sv
// tb/tb_mod5_seq_monitor.sv - directed bench for mod5_seq_monitor
module tb_mod5_seq_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] cnt_in;
    logic       en;
    logic       clr;
    logic       locked, err, illegal, wrap;
    logic [7:0] err_cnt, wrap_cnt;

    int checks = 0;
    int errors = 0;

    mod5_seq_monitor #(.LOCK_N(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .en       (en),
        .clr      (clr),
        .locked   (locked),
        .err      (err),
        .illegal  (illegal),
        .wrap     (wrap),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic e, input logic i,
                           input logic w, input logic [7:0] ec, input logic [7:0] wc);
        chk({tag, ".locked"},   {7'd0, locked},  {7'd0, l});
        chk({tag, ".err"},      {7'd0, err},     {7'd0, e});
        chk({tag, ".illegal"},  {7'd0, illegal}, {7'd0, i});
        chk({tag, ".wrap"},     {7'd0, wrap},    {7'd0, w});
        chk({tag, ".err_cnt"},  err_cnt,  ec);
        chk({tag, ".wrap_cnt"}, wrap_cnt, wc);
    endtask

    // drive one sample, then look at the registered response just after the edge
    task automatic step(input logic e, input logic [2:0] c, input logic cl);
        en     = e;
        cnt_in = c;
        clr    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_from_hunt();
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cnt_in = 3'd0; clr = 1'b0;
        #2;
        chk_all("reset", 0, 0, 0, 0, 8'd0, 8'd0);
        #10 rst = 1'b1;

        // lock and wrap
        step(1'b1, 3'd0, 1'b0); chk_all("seq0", 0, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd1, 1'b0); chk_all("seq1", 0, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd2, 1'b0); chk_all("seq2", 0, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd3, 1'b0); chk_all("seq3", 1, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd4, 1'b0); chk_all("seq4", 1, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd0, 1'b0); chk_all("seqwrap", 1, 0, 0, 1, 8'd0, 8'd1);
        step(1'b1, 3'd1, 1'b0); chk_all("seqafter", 1, 0, 0, 0, 8'd0, 8'd1);

        // repeated value while locked is a break; relock through a CHECK 4->0
        step(1'b1, 3'd2, 1'b0); chk_all("pre_break", 1, 0, 0, 0, 8'd0, 8'd1);
        step(1'b1, 3'd2, 1'b0); chk_all("break", 0, 1, 0, 0, 8'd1, 8'd1);
        step(1'b1, 3'd3, 1'b0); chk_all("relock1", 0, 0, 0, 0, 8'd1, 8'd1);
        step(1'b1, 3'd4, 1'b0); chk_all("relock2", 0, 0, 0, 0, 8'd1, 8'd1);
        step(1'b1, 3'd0, 1'b0); chk_all("relock3", 1, 0, 0, 0, 8'd1, 8'd1);

        // illegal while locked, illegal while hunting
        step(1'b1, 3'd6, 1'b0); chk_all("lock_ill", 0, 1, 1, 0, 8'd2, 8'd1);
        step(1'b1, 3'd7, 1'b0); chk_all("hunt_ill", 0, 0, 1, 0, 8'd2, 8'd1);
        step(1'b1, 3'd3, 1'b0); chk_all("hunt_ok", 0, 0, 0, 0, 8'd2, 8'd1);
        step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd0, 1'b0); chk_all("hunt_c0", 0, 0, 0, 0, 8'd2, 8'd1);
        step(1'b1, 3'd1, 1'b0); chk_all("hunt_lock", 1, 0, 0, 0, 8'd2, 8'd1);

        // en low holds everything
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
            chk_all("en_low", 1, 0, 0, 0, 8'd2, 8'd1);
        end
        step(1'b1, 3'd2, 1'b0); chk_all("resume", 1, 0, 0, 0, 8'd2, 8'd1);

        // CHECK mismatch and CHECK illegal produce no err
        step(1'b1, 3'd2, 1'b0); chk_all("rep_break", 0, 1, 0, 0, 8'd3, 8'd1);
        step(1'b1, 3'd4, 1'b0); chk_all("chk_mis", 0, 0, 0, 0, 8'd3, 8'd1);
        step(1'b1, 3'd5, 1'b0); chk_all("chk_ill", 0, 0, 1, 0, 8'd3, 8'd1);

        // reach err_cnt=5 while locked, then reset asynchronously
        lock_from_hunt(); step(1'b1, 3'd7, 1'b0);
        lock_from_hunt(); step(1'b1, 3'd7, 1'b0);
        lock_from_hunt(); chk_all("pre_rst", 1, 0, 0, 0, 8'd5, 8'd1);
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 8'd0, 8'd0);
        #2 rst = 1'b1;
        step(1'b1, 3'd1, 1'b0); chk_all("post_rst1", 0, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0); chk_all("post_rst3", 0, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd4, 1'b0); chk_all("post_rst4", 1, 0, 0, 0, 8'd0, 8'd0);

        // wrap_cnt rolls over
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 3'd0, 1'b0);
            step(1'b1, 3'd1, 1'b0);
            step(1'b1, 3'd2, 1'b0);
            step(1'b1, 3'd3, 1'b0);
            step(1'b1, 3'd4, 1'b0);
        end
        chk_all("wrap255", 1, 0, 0, 0, 8'd0, 8'd255);
        step(1'b1, 3'd0, 1'b0); chk_all("wrap_roll", 1, 0, 0, 1, 8'd0, 8'd0);

        // err_cnt saturates
        step(1'b1, 3'd7, 1'b0); chk_all("sat_first", 0, 1, 1, 0, 8'd1, 8'd0);
        for (int i = 0; i < 259; i++) begin
            lock_from_hunt();
            step(1'b1, 3'd7, 1'b0);
        end
        chk_all("sat", 0, 1, 1, 0, 8'd255, 8'd0);

        // clr wins over a coincident error and leaves state alone
        lock_from_hunt();
        step(1'b1, 3'd7, 1'b1); chk_all("clr_err", 0, 1, 1, 0, 8'd0, 8'd0);
        lock_from_hunt();
        step(1'b1, 3'd0, 1'b0); chk_all("mis_err", 0, 1, 0, 0, 8'd1, 8'd0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0); chk_all("relock_c", 1, 0, 0, 0, 8'd1, 8'd0);
        step(1'b0, 3'd5, 1'b1); chk_all("clr_en0", 1, 0, 0, 0, 8'd0, 8'd0);
        step(1'b1, 3'd4, 1'b0); chk_all("after_clr", 1, 0, 0, 0, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
